// File: rtl/wbs_timeout_pkg.sv
// Shared types and constants for the mgmt-to-FSIC Wishbone timeout bridge.
package wbs_timeout_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [7:0]  OFF_STATUS       = 8'h00;
  localparam logic [7:0]  OFF_LAST         = 8'h04;
  localparam logic [7:0]  OFF_TCFG         = 8'h08;
  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

  // Event counter that sticks at its maximum instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'hFF) begin
      return v;
    end else begin
      return v + 8'd1;
    end
  endfunction

endpackage

// File: rtl/wbs_timeout_regs.sv
// Local status/config registers: timeout status, last failing address and
// the programmable timeout limit, with byte-enable writes and a read mux.
module wbs_timeout_regs
  import wbs_timeout_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_DEFAULT = 16'd255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_wr_en,
  input  logic [7:0]  i_offset,
  input  logic [15:0] i_wdat,
  input  logic [1:0]  i_sel,
  input  logic        i_tmo_evt,
  input  logic [31:0] i_tmo_addr,
  output logic [31:0] o_rdata,
  output logic [15:0] o_tcfg,
  output logic        o_sticky
);

  logic        r_sticky;
  logic [7:0]  r_tcount;
  logic [31:0] r_last;
  logic [15:0] r_tcfg;
  logic        w_clr;
  logic        w_tcfg_wr;

  assign w_clr     = i_wr_en && (i_offset == OFF_STATUS) && i_sel[0] && i_wdat[0];
  assign w_tcfg_wr = i_wr_en && (i_offset == OFF_TCFG);

  // Status bookkeeping; a clear in the same cycle as a timeout discards the timeout.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sticky <= 1'b0;
      r_tcount <= 8'd0;
      r_last   <= 32'd0;
    end else if (w_clr) begin
      r_sticky <= 1'b0;
      r_tcount <= 8'd0;
    end else if (i_tmo_evt) begin
      r_sticky <= 1'b1;
      r_tcount <= sat_inc8(r_tcount);
      r_last   <= i_tmo_addr;
    end
  end

  // Timeout limit, each byte individually writable.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tcfg <= TIMEOUT_DEFAULT;
    end else if (w_tcfg_wr) begin
      if (i_sel[0]) begin
        r_tcfg[7:0] <= i_wdat[7:0];
      end
      if (i_sel[1]) begin
        r_tcfg[15:8] <= i_wdat[15:8];
      end
    end
  end

  // Read mux; unmapped offsets read as zero.
  always_comb begin
    o_rdata = 32'd0;
    case (i_offset)
      OFF_STATUS: o_rdata = {16'd0, r_tcount, 7'd0, r_sticky};
      OFF_LAST:   o_rdata = r_last;
      OFF_TCFG:   o_rdata = {16'd0, r_tcfg};
      default:    o_rdata = 32'd0;
    endcase
  end

  assign o_tcfg   = r_tcfg;
  assign o_sticky = r_sticky;

endmodule

// File: rtl/wbs_timeout_bridge.sv
// Forwards mgmt Wishbone accesses to FSIC and guarantees an upstream ack,
// substituting an error response when FSIC stays silent too long.
module wbs_timeout_bridge
  import wbs_timeout_pkg::*;
#(
  parameter logic [31:0] LOCAL_BASE      = 32'h3FFF_FF00,
  parameter logic [15:0] TIMEOUT_DEFAULT = 16'd255,
  parameter logic [31:0] ERR_DATA        = ERR_DATA_DEFAULT
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  output logic        m_we_o,
  output logic [3:0]  m_sel_o,
  output logic [31:0] m_adr_o,
  output logic [31:0] m_dat_o,
  input  logic        m_ack_i,
  input  logic [31:0] m_dat_i,
  output logic        timeout_irq
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_ack;
  logic        w_ack_nxt;
  logic [31:0] r_dat;
  logic [31:0] w_dat_nxt;
  logic        r_m_cyc;
  logic        w_m_cyc_nxt;
  logic        r_m_we;
  logic        w_m_we_nxt;
  logic [3:0]  r_m_sel;
  logic [3:0]  w_m_sel_nxt;
  logic [31:0] r_m_adr;
  logic [31:0] w_m_adr_nxt;
  logic [31:0] r_m_dat;
  logic [31:0] w_m_dat_nxt;
  logic [15:0] r_cnt;
  logic [15:0] w_cnt_nxt;

  logic        w_req;
  logic        w_hit;
  logic        w_reg_wr;
  logic        w_tmo_hit;
  logic        w_tmo_evt;
  logic [31:0] w_reg_rdata;
  logic [15:0] w_tcfg;
  logic        w_sticky;

  assign w_req     = wbs_cyc_i && wbs_stb_i;
  assign w_hit     = (wbs_adr_i[31:8] == LOCAL_BASE[31:8]);
  assign w_reg_wr  = (r_state == IDLE) && w_req && w_hit && wbs_we_i;
  assign w_tmo_hit = (w_tcfg != 16'd0) && (r_cnt == (w_tcfg - 16'd1));

  wbs_timeout_regs #(
    .TIMEOUT_DEFAULT (TIMEOUT_DEFAULT)
  ) u_regs (
    .i_clk      (wb_clk_i),
    .i_rst      (wb_rst_i),
    .i_wr_en    (w_reg_wr),
    .i_offset   (wbs_adr_i[7:0]),
    .i_wdat     (wbs_dat_i[15:0]),
    .i_sel      (wbs_sel_i[1:0]),
    .i_tmo_evt  (w_tmo_evt),
    .i_tmo_addr (r_m_adr),
    .o_rdata    (w_reg_rdata),
    .o_tcfg     (w_tcfg),
    .o_sticky   (w_sticky)
  );

  // State, response and downstream request registers.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= IDLE;
      r_ack   <= 1'b0;
      r_dat   <= 32'd0;
      r_m_cyc <= 1'b0;
      r_m_we  <= 1'b0;
      r_m_sel <= 4'd0;
      r_m_adr <= 32'd0;
      r_m_dat <= 32'd0;
      r_cnt   <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      r_ack   <= w_ack_nxt;
      r_dat   <= w_dat_nxt;
      r_m_cyc <= w_m_cyc_nxt;
      r_m_we  <= w_m_we_nxt;
      r_m_sel <= w_m_sel_nxt;
      r_m_adr <= w_m_adr_nxt;
      r_m_dat <= w_m_dat_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic. Ack and response data default low, so the upstream
  // data bus is zero whenever ack is not being returned.
  always_comb begin
    w_state_nxt = r_state;
    w_ack_nxt   = 1'b0;
    w_dat_nxt   = 32'd0;
    w_m_cyc_nxt = r_m_cyc;
    w_m_we_nxt  = r_m_we;
    w_m_sel_nxt = r_m_sel;
    w_m_adr_nxt = r_m_adr;
    w_m_dat_nxt = r_m_dat;
    w_cnt_nxt   = r_cnt;
    w_tmo_evt   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req && w_hit) begin
          w_ack_nxt   = 1'b1;
          w_dat_nxt   = wbs_we_i ? 32'd0 : w_reg_rdata;
          w_state_nxt = RESP;
        end else if (w_req) begin
          w_m_cyc_nxt = 1'b1;
          w_m_we_nxt  = wbs_we_i;
          w_m_sel_nxt = wbs_sel_i;
          w_m_adr_nxt = wbs_adr_i;
          w_m_dat_nxt = wbs_dat_i;
          w_cnt_nxt   = 16'd0;
          w_state_nxt = FWD;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      FWD: begin
        w_cnt_nxt = r_cnt + 16'd1;
        // A withdrawn master gets no ack, even if FSIC answers this cycle.
        if (!wbs_cyc_i) begin
          w_m_cyc_nxt = 1'b0;
          w_state_nxt = IDLE;
        end else if (m_ack_i) begin
          w_m_cyc_nxt = 1'b0;
          w_ack_nxt   = 1'b1;
          w_dat_nxt   = r_m_we ? 32'd0 : m_dat_i;
          w_state_nxt = RESP;
        end else if (w_tmo_hit) begin
          w_m_cyc_nxt = 1'b0;
          w_ack_nxt   = 1'b1;
          w_dat_nxt   = r_m_we ? 32'd0 : ERR_DATA;
          w_tmo_evt   = 1'b1;
          w_state_nxt = RESP;
        end else begin
          w_state_nxt = FWD;
        end
      end
      RESP: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_m_cyc_nxt = 1'b0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign wbs_ack_o   = r_ack;
  assign wbs_dat_o   = r_dat;
  assign m_cyc_o     = r_m_cyc;
  assign m_stb_o     = r_m_cyc;
  assign m_we_o      = r_m_we;
  assign m_sel_o     = r_m_sel;
  assign m_adr_o     = r_m_adr;
  assign m_dat_o     = r_m_dat;
  assign timeout_irq = w_sticky;

endmodule

// File: tb/tb_wbs_timeout_bridge.sv
// Bench for wbs_timeout_bridge: directed scenarios plus randomized traffic
// checked against a transaction-level model of the bridge's rules.
module tb_wbs_timeout_bridge;

  localparam logic [31:0] LBASE  = 32'h3FFF_FF00;
  localparam logic [31:0] ERRD   = 32'hDEAD_BEEF;
  localparam int          BUDGET = 400;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        wbs_stb_i = 1'b0, wbs_cyc_i = 1'b0, wbs_we_i = 1'b0;
  logic [3:0]  wbs_sel_i = 4'h0;
  logic [31:0] wbs_adr_i = 32'h0, wbs_dat_i = 32'h0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        m_cyc_o, m_stb_o, m_we_o;
  logic [3:0]  m_sel_o;
  logic [31:0] m_adr_o, m_dat_o;
  logic        m_ack_i = 1'b0;
  logic [31:0] m_dat_i = 32'h0;
  logic        timeout_irq;

  always #5 wb_clk_i = ~wb_clk_i;

  wbs_timeout_bridge dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o), .m_sel_o(m_sel_o),
    .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_ack_i(m_ack_i), .m_dat_i(m_dat_i),
    .timeout_irq(timeout_irq)
  );

  int total = 0;
  int bad   = 0;

  // Reference model of the software-visible state.
  logic        mdl_sticky;
  int          mdl_tcount;
  logic [31:0] mdl_last;
  logic [15:0] mdl_tcfg;

  // Observations from the most recent transfer.
  int          obs_ack_cyc, obs_stb_cyc;
  logic [31:0] obs_rdat, obs_post_dat, obs_m_adr, obs_m_dat;
  logic [3:0]  obs_m_sel;
  logic        obs_m_we, obs_post_ack;

  function automatic void mdl_reset();
    mdl_sticky = 1'b0; mdl_tcount = 0; mdl_last = 32'h0; mdl_tcfg = 16'd255;
  endfunction

  function automatic logic [31:0] mdl_read(input logic [7:0] off);
    if (off == 8'h00) return {16'h0, 8'(mdl_tcount), 7'h0, mdl_sticky};
    else if (off == 8'h04) return mdl_last;
    else if (off == 8'h08) return {16'h0, mdl_tcfg};
    else return 32'h0;
  endfunction

  function automatic void mdl_write(input logic [7:0] off, input logic [31:0] d, input logic [3:0] s);
    if (off == 8'h00 && s[0] && d[0]) begin mdl_sticky = 1'b0; mdl_tcount = 0; end
    if (off == 8'h08 && s[0]) mdl_tcfg[7:0] = d[7:0];
    if (off == 8'h08 && s[1]) mdl_tcfg[15:8] = d[15:8];
  endfunction

  // FSIC acking in the a-th cycle of m_stb (0-based, -1 = never).
  function automatic bit mdl_times_out(input int a);
    return (mdl_tcfg != 16'd0) && (a < 0 || a >= int'(mdl_tcfg));
  endfunction

  function automatic int mdl_exp_ack(input int a);
    return mdl_times_out(a) ? int'(mdl_tcfg) + 1 : a + 2;
  endfunction

  function automatic void mdl_timeout(input logic [31:0] adr);
    mdl_sticky = 1'b1;
    if (mdl_tcount < 255) mdl_tcount = mdl_tcount + 1;
    mdl_last = adr;
  endfunction

  // One Wishbone classic transfer; the request is sampled in cycle 0 and
  // obs_ack_cyc is the cycle in which ack is seen (-1 if the budget ran out).
  task automatic xfer(input logic [31:0] adr, input logic [31:0] dat, input logic we,
                      input logic [3:0] sel, input int ack_after, input logic [31:0] fdat);
    int first;
    first = -1; obs_ack_cyc = -1; obs_stb_cyc = 0; obs_rdat = 32'h0;
    obs_m_adr = 32'h0; obs_m_dat = 32'h0; obs_m_sel = 4'h0; obs_m_we = 1'b0;
    @(negedge wb_clk_i);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we; wbs_sel_i = sel;
    wbs_adr_i = adr; wbs_dat_i = dat;
    for (int n = 1; n <= BUDGET; n++) begin
      @(negedge wb_clk_i);
      if (m_stb_o === 1'b1) begin
        if (first < 0) begin
          first = n; obs_m_adr = m_adr_o; obs_m_dat = m_dat_o;
          obs_m_sel = m_sel_o; obs_m_we = m_we_o;
        end
        obs_stb_cyc++;
      end
      if (wbs_ack_o === 1'b1) begin
        obs_ack_cyc = n; obs_rdat = wbs_dat_o;
        break;
      end
      if (m_stb_o === 1'b1 && ack_after >= 0 && (n - first) == ack_after) begin
        m_ack_i = 1'b1; m_dat_i = fdat;
      end else begin
        m_ack_i = 1'b0; m_dat_i = $urandom;
      end
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; m_ack_i = 1'b0; m_dat_i = 32'h0;
    @(negedge wb_clk_i);
    obs_post_ack = wbs_ack_o; obs_post_dat = wbs_dat_o;
  endtask

  task automatic test_reset();
    wb_rst_i = 1'b1;
    repeat (3) @(negedge wb_clk_i);
    total++;
    if ({wbs_ack_o, wbs_dat_o, m_cyc_o, m_stb_o, m_we_o, m_sel_o, m_adr_o, m_dat_o, timeout_irq} !== 105'h0)
      begin bad++; $display("FAIL reset_outputs: got ack=%b dat=%h mcyc=%b irq=%b want all 0", wbs_ack_o, wbs_dat_o, m_cyc_o, timeout_irq); end
    wb_rst_i = 1'b0;
    mdl_reset();
    for (int k = 0; k < 3; k++) begin
      logic [7:0] off;
      off = 8'(k * 4);
      xfer(LBASE | {24'h0, off}, 32'h0, 1'b0, 4'hF, -1, 32'h0);
      total++;
      if (obs_ack_cyc != 1 || obs_rdat !== mdl_read(off))
        begin bad++; $display("FAIL reset_reg_%0h: got cyc=%0d dat=%h want cyc=1 dat=%h", off, obs_ack_cyc, obs_rdat, mdl_read(off)); end
    end
  endtask

  task automatic test_fwd_read();
    xfer(32'h3000_0010, 32'h0, 1'b0, 4'hF, 3, 32'h1234_5678);
    total++;
    if (obs_ack_cyc != mdl_exp_ack(3) || obs_rdat !== 32'h1234_5678 || obs_stb_cyc != 4)
      begin bad++; $display("FAIL fwd_read: got cyc=%0d dat=%h stb=%0d want cyc=%0d dat=12345678 stb=4", obs_ack_cyc, obs_rdat, obs_stb_cyc, mdl_exp_ack(3)); end
    total++;
    if (obs_m_adr !== 32'h3000_0010 || obs_m_we !== 1'b0 || obs_post_ack !== 1'b0 || obs_post_dat !== 32'h0)
      begin bad++; $display("FAIL fwd_read_bus: got madr=%h mwe=%b post_ack=%b post_dat=%h", obs_m_adr, obs_m_we, obs_post_ack, obs_post_dat); end
    xfer(LBASE, 32'h0, 1'b0, 4'hF, -1, 32'h0);
    total++;
    if (obs_rdat !== mdl_read(8'h00))
      begin bad++; $display("FAIL fwd_read_status: got %h want %h", obs_rdat, mdl_read(8'h00)); end
  endtask

  task automatic test_timeout();
    xfer(LBASE | 32'h08, 32'h4, 1'b1, 4'b0011, -1, 32'h0);
    mdl_write(8'h08, 32'h4, 4'b0011);
    xfer(32'h3000_0020, 32'h0, 1'b0, 4'hF, -1, 32'h0);
    total++;
    if (obs_stb_cyc != 4 || obs_ack_cyc != mdl_exp_ack(-1) || obs_rdat !== ERRD)
      begin bad++; $display("FAIL timeout_resp: got stb=%0d cyc=%0d dat=%h want stb=4 cyc=%0d dat=%h", obs_stb_cyc, obs_ack_cyc, obs_rdat, mdl_exp_ack(-1), ERRD); end
    mdl_timeout(32'h3000_0020);
    total++;
    if (timeout_irq !== mdl_sticky)
      begin bad++; $display("FAIL timeout_irq: got %b want %b", timeout_irq, mdl_sticky); end
    xfer(LBASE, 32'h0, 1'b0, 4'hF, -1, 32'h0);
    total++;
    if (obs_rdat !== mdl_read(8'h00))
      begin bad++; $display("FAIL timeout_status: got %h want %h", obs_rdat, mdl_read(8'h00)); end
    xfer(LBASE | 32'h04, 32'h0, 1'b0, 4'hF, -1, 32'h0);
    total++;
    if (obs_rdat !== mdl_read(8'h04))
      begin bad++; $display("FAIL timeout_last: got %h want %h", obs_rdat, mdl_read(8'h04)); end
  endtask

  task automatic test_collision();
    xfer(32'h3000_0030, 32'h0, 1'b0, 4'hF, 3, 32'hA5A5_A5A5);
    total++;
    if (obs_rdat !== 32'hA5A5_A5A5 || obs_ack_cyc != mdl_exp_ack(3))
      begin bad++; $display("FAIL collision_resp: got dat=%h cyc=%0d want dat=a5a5a5a5 cyc=%0d", obs_rdat, obs_ack_cyc, mdl_exp_ack(3)); end
    xfer(LBASE, 32'h0, 1'b0, 4'hF, -1, 32'h0);
    total++;
    if (obs_rdat !== mdl_read(8'h00))
      begin bad++; $display("FAIL collision_status: got %h want %h", obs_rdat, mdl_read(8'h00)); end
  endtask

  task automatic test_local();
    xfer(LBASE | 32'h08, 32'h0000_0010, 1'b1, 4'b0001, -1, 32'h0);
    mdl_write(8'h08, 32'h0000_0010, 4'b0001);
    total++;
    if (obs_ack_cyc != 1 || obs_rdat !== 32'h0 || obs_stb_cyc != 0)
      begin bad++; $display("FAIL local_write: got cyc=%0d dat=%h stb=%0d want cyc=1 dat=0 stb=0", obs_ack_cyc, obs_rdat, obs_stb_cyc); end
    xfer(LBASE | 32'h08, 32'h0, 1'b0, 4'hF, -1, 32'h0);
    total++;
    if (obs_rdat !== mdl_read(8'h08))
      begin bad++; $display("FAIL local_tcfg_rb: got %h want %h", obs_rdat, mdl_read(8'h08)); end
    xfer(LBASE, 32'h1, 1'b1, 4'hF, -1, 32'h0);
    mdl_write(8'h00, 32'h1, 4'hF);
    xfer(LBASE, 32'h0, 1'b0, 4'hF, -1, 32'h0);
    total++;
    if (obs_rdat !== mdl_read(8'h00) || timeout_irq !== mdl_sticky)
      begin bad++; $display("FAIL local_clear: got status=%h irq=%b want status=%h irq=%b", obs_rdat, timeout_irq, mdl_read(8'h00), mdl_sticky); end
  endtask

  task automatic test_abort();
    logic [31:0] st_before;
    int acks;
    xfer(LBASE | 32'h08, 32'h20, 1'b1, 4'b0011, -1, 32'h0);
    mdl_write(8'h08, 32'h20, 4'b0011);
    st_before = mdl_read(8'h00);
    @(negedge wb_clk_i);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_sel_i = 4'hF; wbs_adr_i = 32'h3000_0040;
    repeat (2) @(negedge wb_clk_i);
    total++;
    if (m_stb_o !== 1'b1)
      begin bad++; $display("FAIL abort_stb_up: got %b want 1", m_stb_o); end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    @(negedge wb_clk_i);
    total++;
    if ({m_cyc_o, m_stb_o, wbs_ack_o} !== 3'b000)
      begin bad++; $display("FAIL abort_drop: got cyc/stb/ack=%b%b%b want 000", m_cyc_o, m_stb_o, wbs_ack_o); end
    acks = 0;
    repeat (4) begin
      @(negedge wb_clk_i);
      if (wbs_ack_o !== 1'b0) acks++;
    end
    total++;
    if (acks != 0)
      begin bad++; $display("FAIL abort_no_ack: got %0d acks want 0", acks); end
    xfer(LBASE, 32'h0, 1'b0, 4'hF, -1, 32'h0);
    total++;
    if (obs_ack_cyc != 1 || obs_rdat !== st_before)
      begin bad++; $display("FAIL abort_idle: got cyc=%0d status=%h want cyc=1 status=%h", obs_ack_cyc, obs_rdat, st_before); end
  endtask

  task automatic test_reset_mid();
    int acks;
    xfer(LBASE | 32'h08, 32'h4, 1'b1, 4'b0011, -1, 32'h0);
    mdl_write(8'h08, 32'h4, 4'b0011);
    xfer(32'h3000_0080, 32'h0, 1'b0, 4'hF, -1, 32'h0);
    mdl_timeout(32'h3000_0080);
    total++;
    if (obs_rdat !== ERRD || timeout_irq !== 1'b1)
      begin bad++; $display("FAIL rstmid_pre: got dat=%h irq=%b want dat=%h irq=1", obs_rdat, timeout_irq, ERRD); end
    @(negedge wb_clk_i);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1; wbs_sel_i = 4'hA;
    wbs_adr_i = 32'h3000_0090; wbs_dat_i = 32'h5555_AAAA;
    repeat (2) @(negedge wb_clk_i);
    total++;
    if (m_stb_o !== 1'b1 || m_dat_o !== 32'h5555_AAAA || m_sel_o !== 4'hA || m_we_o !== 1'b1)
      begin bad++; $display("FAIL rstmid_fwd: got stb=%b dat=%h sel=%h we=%b", m_stb_o, m_dat_o, m_sel_o, m_we_o); end
    wb_rst_i = 1'b1;
    @(negedge wb_clk_i);
    total++;
    if ({wbs_ack_o, wbs_dat_o, m_cyc_o, m_stb_o, m_we_o, m_sel_o, m_adr_o, m_dat_o, timeout_irq} !== 105'h0)
      begin bad++; $display("FAIL rstmid_outputs: got mcyc=%b madr=%h mdat=%h irq=%b want all 0", m_cyc_o, m_adr_o, m_dat_o, timeout_irq); end
    wb_rst_i = 1'b0; wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    mdl_reset();
    acks = 0;
    repeat (3) begin
      @(negedge wb_clk_i);
      if (wbs_ack_o !== 1'b0) acks++;
    end
    total++;
    if (acks != 0)
      begin bad++; $display("FAIL rstmid_no_ack: got %0d acks want 0", acks); end
    xfer(LBASE | 32'h08, 32'h0, 1'b0, 4'hF, -1, 32'h0);
    total++;
    if (obs_rdat !== mdl_read(8'h08))
      begin bad++; $display("FAIL rstmid_tcfg: got %h want %h", obs_rdat, mdl_read(8'h08)); end
    xfer(LBASE, 32'h0, 1'b0, 4'hF, -1, 32'h0);
    total++;
    if (obs_rdat !== mdl_read(8'h00))
      begin bad++; $display("FAIL rstmid_status: got %h want %h", obs_rdat, mdl_read(8'h00)); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 80; it++) begin
      int kind, a, es, ea;
      bit to;
      logic [7:0] off;
      logic [31:0] adr, dat, fd, ed;
      logic [3:0] sel;
      logic we;
      kind = int'($urandom_range(0, 3));
      if (kind == 0) begin
        case ($urandom_range(0, 3))
          0: off = 8'h00;
          1: off = 8'h04;
          2: off = 8'h08;
          default: off = 8'($urandom_range(0, 255));
        endcase
        ed = mdl_read(off);
        xfer(LBASE | {24'h0, off}, $urandom, 1'b0, 4'hF, -1, 32'h0);
        total++;
        if (obs_ack_cyc != 1 || obs_rdat !== ed || obs_stb_cyc != 0)
          begin bad++; $display("FAIL rnd_lrd it=%0d off=%h: got cyc=%0d dat=%h want cyc=1 dat=%h", it, off, obs_ack_cyc, obs_rdat, ed); end
      end else if (kind == 1) begin
        case ($urandom_range(0, 2))
          0: off = 8'h00;
          1: off = 8'h08;
          default: off = 8'h0C;
        endcase
        dat = 32'($urandom_range(0, 12));
        sel = 4'($urandom_range(0, 15));
        xfer(LBASE | {24'h0, off}, dat, 1'b1, sel, -1, 32'h0);
        mdl_write(off, dat, sel);
        total++;
        if (obs_ack_cyc != 1 || obs_rdat !== 32'h0)
          begin bad++; $display("FAIL rnd_lwr it=%0d: got cyc=%0d dat=%h want cyc=1 dat=0", it, obs_ack_cyc, obs_rdat); end
      end else begin
        adr = {8'h30, 24'($urandom)} & 32'hFFFF_FFFC;
        dat = $urandom; fd = $urandom;
        we  = 1'($urandom_range(0, 1));
        sel = 4'($urandom_range(1, 15));
        a   = int'($urandom_range(0, 13)) - 1;
        if (mdl_tcfg == 16'd0 && a < 0) a = 4;
        to = mdl_times_out(a);
        ea = mdl_exp_ack(a);
        es = to ? int'(mdl_tcfg) : a + 1;
        ed = we ? 32'h0 : (to ? ERRD : fd);
        xfer(adr, dat, we, sel, a, fd);
        total++;
        if (obs_ack_cyc != ea || obs_stb_cyc != es || obs_rdat !== ed)
          begin bad++; $display("FAIL rnd_fwd it=%0d a=%0d tcfg=%0d: got cyc=%0d stb=%0d dat=%h want cyc=%0d stb=%0d dat=%h", it, a, mdl_tcfg, obs_ack_cyc, obs_stb_cyc, obs_rdat, ea, es, ed); end
        total++;
        if ({obs_m_adr, obs_m_dat, obs_m_sel, obs_m_we} !== {adr, dat, sel, we})
          begin bad++; $display("FAIL rnd_mbus it=%0d: got adr=%h dat=%h sel=%h we=%b want adr=%h dat=%h sel=%h we=%b", it, obs_m_adr, obs_m_dat, obs_m_sel, obs_m_we, adr, dat, sel, we); end
        if (to) mdl_timeout(adr);
      end
      total++;
      if (obs_post_ack !== 1'b0 || obs_post_dat !== 32'h0 || timeout_irq !== mdl_sticky)
        begin bad++; $display("FAIL rnd_post it=%0d: got ack=%b dat=%h irq=%b want ack=0 dat=0 irq=%b", it, obs_post_ack, obs_post_dat, timeout_irq, mdl_sticky); end
    end
  endtask

  task automatic test_saturation();
    xfer(LBASE | 32'h08, 32'h1, 1'b1, 4'b0011, -1, 32'h0);
    mdl_write(8'h08, 32'h1, 4'b0011);
    for (int k = 0; k < 260; k++) begin
      logic [31:0] adr;
      adr = 32'h3000_0100 + 32'(k * 4);
      xfer(adr, 32'h0, 1'b0, 4'hF, -1, 32'h0);
      total++;
      if (obs_ack_cyc != mdl_exp_ack(-1) || obs_rdat !== ERRD)
        begin bad++; $display("FAIL sat_to k=%0d: got cyc=%0d dat=%h want cyc=%0d dat=%h", k, obs_ack_cyc, obs_rdat, mdl_exp_ack(-1), ERRD); end
      mdl_timeout(adr);
    end
    xfer(LBASE, 32'h0, 1'b0, 4'hF, -1, 32'h0);
    total++;
    if (obs_rdat !== mdl_read(8'h00) || timeout_irq !== 1'b1)
      begin bad++; $display("FAIL sat_status: got %h irq=%b want %h irq=1", obs_rdat, timeout_irq, mdl_read(8'h00)); end
    xfer(LBASE | 32'h04, 32'h0, 1'b0, 4'hF, -1, 32'h0);
    total++;
    if (obs_rdat !== mdl_read(8'h04))
      begin bad++; $display("FAIL sat_last: got %h want %h", obs_rdat, mdl_read(8'h04)); end
  endtask

  initial begin
    mdl_reset();
    test_reset();
    test_fwd_read();
    test_timeout();
    test_collision();
    test_local();
    test_abort();
    test_reset_mid();
    test_random();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wbs_timeout_bridge.md
Name: wbs_timeout_bridge

Overview:
- Sits between the Caravel management Wishbone slave port and the FSIC Wishbone slave input.
- Forwards every mgmt transaction to FSIC and guarantees the mgmt core always receives an ack. If FSIC does not ack within a programmable number of cycles, the bridge returns a terminating ack with an error pattern.
- Exposes a small local status/config register window and a level interrupt for timeout events.

Parameters:
- LOCAL_BASE, 32'h3FFF_FF00: base of the local register window; match uses adr[31:8] only.
- TIMEOUT_DEFAULT, 16'd255: reset value of TIMEOUT_CFG.
- ERR_DATA, 32'hDEAD_BEEF: read data returned on a timed-out access.

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  synchronous active-high reset
- wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  upstream Wishbone control from mgmt
- wbs_sel_i  in  4  upstream byte enables
- wbs_adr_i, wbs_dat_i  in  32 each  upstream address / write data
- wbs_ack_o  out  1  upstream ack
- wbs_dat_o  out  32  upstream read data
- m_cyc_o, m_stb_o, m_we_o  out  1 each  downstream Wishbone control to FSIC
- m_sel_o  out  4  downstream byte enables
- m_adr_o, m_dat_o  out  32 each  downstream address / write data
- m_ack_i  in  1  downstream ack
- m_dat_i  in  32  downstream read data
- timeout_irq  out  1  level interrupt; equals STATUS.sticky

Behaviour:
- Interface is fixed: single clock wb_clk_i; wb_rst_i is synchronous and active-high.
- Reset (any cycle, including mid-transaction):
  - state=IDLE.
  - All outputs 0.
  - STATUS=0, LAST_ADDR=0, TIMEOUT_CFG=TIMEOUT_DEFAULT.
  - An in-flight transaction is dropped with no ack.
- FSM states: IDLE, FWD, RESP.
- IDLE:
  - On wbs_cyc_i & wbs_stb_i with a local address hit (adr[31:8]==LOCAL_BASE[31:8]): perform the register read/write in this cycle, register the response, go to RESP.
  - On any other cyc&stb: register adr/dat/sel/we into the m_* outputs, assert m_cyc_o=m_stb_o=1 in the next cycle, clear cnt, go to FWD.
- FWD:
  - m_* outputs held stable; cnt increments each cycle (16-bit).
  - If m_ack_i=1: latch m_dat_i into the response register, drop m_cyc/m_stb next cycle, go to RESP.
  - Else if TIMEOUT_CFG!=0 and cnt==TIMEOUT_CFG-1: set sticky, increment tcount (saturating at 255), capture LAST_ADDR=m_adr_o, response=ERR_DATA, drop m_cyc/m_stb, go to RESP.
  - m_ack_i in the same cycle as the timeout condition: ack wins; no timeout is recorded.
  - wbs_cyc_i deasserted while in FWD (mgmt abort): drop m_cyc/m_stb next cycle, go to IDLE, no upstream ack.
  - TIMEOUT_CFG==0 disables the timeout; FWD waits indefinitely.
- RESP: wbs_ack_o=1 for exactly one cycle with wbs_dat_o valid (0 for writes), then go to IDLE. wbs_dat_o=0 whenever ack is low.
- Latency:
  - Local access: request seen in cycle 0, ack in cycle 1.
  - Forwarded access: m_stb_o rises in cycle 1; m_ack_i in cycle k gives wbs_ack_o in cycle k+1.
- Local registers (offset = adr[7:0]):
  - 0x00 STATUS: [0] sticky timeout, [15:8] tcount. A write with dat[0]=1 and sel[0]=1 clears both fields. A timeout in the same cycle as a clear is lost; the clear wins.
  - 0x04 LAST_ADDR: read-only.
  - 0x08 TIMEOUT_CFG: [15:0] read/write; sel[0] and sel[1] gate the two bytes.
  - Other offsets: read 0, writes ignored, still acked.
- Upstream requests arriving in FWD or RESP are not accepted; Wishbone classic masters hold stb until ack.

Decomposition:
- Package wbs_timeout_pkg holds:
  - state enum {IDLE, FWD, RESP}
  - register offsets (OFF_STATUS=8'h00, OFF_LAST=8'h04, OFF_TCFG=8'h08)
  - default ERR_DATA constant
- Sub-module wbs_timeout_regs: STATUS/LAST_ADDR/TIMEOUT_CFG storage, byte-enable write, clear logic, read mux.
- The FSM and counter stay in the top module.

Test Plan:
- Forwarded read: adr 0x3000_0010; FSIC acks 3 cycles after m_stb with 0x1234_5678 -> wbs_ack_o one cycle later, wbs_dat_o=0x1234_5678, STATUS=0.
- Timeout: TIMEOUT_CFG=4; FSIC never acks read of 0x3000_0020 -> m_stb high exactly 4 cycles, then wbs_dat_o=0xDEAD_BEEF with ack; STATUS=0x0101, LAST_ADDR=0x3000_0020, timeout_irq=1.
- Ack/timeout collision: TIMEOUT_CFG=4; m_ack_i asserted on the 4th cycle with 0xA5A5_A5A5 -> wbs_dat_o=0xA5A5_A5A5, STATUS unchanged.
- Local access: write 0x0000_0010 to 0x3FFF_FF08 with sel=4'b0001 -> ack in cycle 1; readback 0x0000_0010. Write 1 to 0x3FFF_FF00 -> STATUS=0, irq low.
- Abort and reset: mgmt drops wbs_cyc_i 2 cycles into FWD -> m_cyc low next cycle, no ack. Separately, wb_rst_i mid-FWD -> next cycle all outputs 0, TIMEOUT_CFG=255.
- Saturation: 260 consecutive timeouts -> tcount=255, sticky=1.
